uart_bus_frame_tx: RTL and testbench
====================================

# uart_bus_frame_tx

Parametrised bus-request framer and UART transmitter for the board-to-board bridge. Accepts one bus request (read or write, configurable address/data width) over a valid/ready handshake, serialises it into a checksummed byte frame, and shifts it out 8N1 on a single UART line. It sits on the request-initiating side of each board, driving the `uart_tx_req` pin. It generalises the fixed 8-bit bridge to arbitrary widths, adds a source ID, read/write frame modes and an integrity byte.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 2
- `ADDR_W`, 16, request address width, 1..32
- `DATA_W`, 8, write data width, 1..32
- `SRC_ID`, 0, 4-bit board ID placed in the command byte
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  framer idle, request accepted on `req_valid && req_ready`
- `req_we`  in  1  1 = write frame, 0 = read frame
- `req_addr`  in  ADDR_W  target address
- `req_wdata`  in  DATA_W  write data (ignored for reads)
- `uart_tx`  out  1  serial line, idle high
- `busy`  out  1  equals `!req_ready`
- `frames_sent`  out  16  completed-frame counter

## Operation
- AB = ceil(ADDR_W/8), DB = ceil(DATA_W/8); address/data zero-extended to AB*8 / DB*8 bits.
- Frame bytes in order: SOF 0xA5; CMD = {we, 3'b000, SRC_ID[3:0]}; address bytes MSB first; data bytes MSB first (writes only); CHK = XOR of CMD, address and data bytes (SOF excluded).
- Frame length N = 3 + AB + (we ? DB : 0).
- Each byte: start bit (0), 8 data bits LSB first, stop bit (1).
- Fields captured into internal registers at the handshake; inputs may change afterwards.
- FSM: IDLE → SOF → CMD → ADDR (AB bytes) → DATA (DB bytes, skipped on read) → CHK → IDLE. A byte index counter walks ADDR/DATA.
- `frames_sent` increments by 1 when CHK stop bit completes; wraps 0xFFFF → 0x0000.
- `req_valid` deasserted before handshake: no effect. `req_valid` while busy: ignored, not queued.

## Timing
- Reset values: `uart_tx`=1, `req_ready`=1, `busy`=0, `frames_sent`=0, FSM=IDLE.
- Handshake at edge k → `uart_tx` low (SOF start bit) from edge k+1.
- Every bit held exactly CLKS_PER_BIT cycles; bytes back-to-back, no idle gap.
- `req_ready` rises exactly N*10*CLKS_PER_BIT cycles after `uart_tx` first falls, same cycle `frames_sent` increments.
- Handshake in that same cycle: next start bit begins at next edge, zero idle bits between frames.
- `rst_n` low mid-frame: `uart_tx` forced high immediately (asynchronous), frame discarded, counter cleared; no partial frame resumes after release.
- `uart_tx` registered; no combinational path from inputs to `uart_tx`. `req_ready` is registered state, not a function of `req_valid`.

## Structure
- Package `uart_frame_pkg`: `SOF_BYTE` (8'hA5), CMD bit positions (`CMD_WE_BIT`=7, ID field [3:0]), frame-state enum, functions `bytes_for(w)` and `frame_len(ab, db, we)`; shared with the future frame receiver.
- Sub-module `uart_tx_core`: byte-level valid/ready in, 8N1 serialiser with baud counter and bit counter, parameter CLKS_PER_BIT. Framer FSM in top feeds it one byte at a time.

## Test plan
- CLKS_PER_BIT=4, ADDR_W=16, DATA_W=8, SRC_ID=0; write addr 0x1234 data 0xFF → bytes A5 80 12 34 FF 59, 240 cycles, `frames_sent`=1.
- SRC_ID=1; read addr 0x0010 → bytes A5 01 00 10 11, 200 cycles, no data byte.
- ADDR_W=12, DATA_W=32; write addr 0xABC data 0xDEADBEEF → A5 80 0A BC DE AD BE EF CHK=0x80^0x0A^0xBC^0xDE^0xAD^0xBE^0xEF, 9 bytes.
- `req_valid` held high with two different requests → second frame's start bit begins one cycle after first frame's final stop bit; first frame's fields unaffected by input change mid-frame.
- Assert `rst_n` low during address byte → `uart_tx`=1 within same cycle, `req_ready`=1, `frames_sent`=0; new request after release produces full correct frame.
- `req_valid` pulses while busy → ignored; exactly one frame on the line, `frames_sent` increments once.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the bridge frame format: framing constants, frame
// states and sizing helpers used by both the transmitter and future receiver.
package uart_frame_pkg;

    localparam logic [7:0] SOF_BYTE   = 8'hA5;
    localparam int         CMD_WE_BIT = 7;
    localparam int         CMD_ID_MSB = 3;
    localparam int         CMD_ID_LSB = 0;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_SOF,
        FS_CMD,
        FS_ADDR,
        FS_DATA,
        FS_CHK
    } frame_state_e;

    function automatic int bytes_for(input int w);
        return (w + 7) / 8;
    endfunction

    function automatic int frame_len(input int ab, input int db, input logic we);
        return 3 + ab + (we ? db : 0);
    endfunction

    function automatic logic [7:0] make_cmd(input logic we, input logic [3:0] id);
        logic [7:0] c;
        c = '0;
        c[CMD_WE_BIT] = we;
        c[CMD_ID_MSB:CMD_ID_LSB] = id;
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 byte serialiser. A byte can be accepted in the last cycle of the
// previous stop bit, so consecutive bytes go out with no idle gap.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       byte_done,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    logic          active;
    logic [8:0]    shift;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic          last_tick;

    assign last_tick  = active && (baud_cnt == '0) && (bit_cnt == 4'd0);
    assign byte_ready = !active || last_tick;
    assign byte_done  = last_tick;

    // bit_cnt counts the bits still to come after the one on the line:
    // 9 = start, 8..1 = data LSB first, 0 = stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            tx       <= 1'b1;
            shift    <= '1;
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
        end else if (byte_valid && byte_ready) begin
            active   <= 1'b1;
            tx       <= 1'b0;
            shift    <= {1'b1, byte_data};
            baud_cnt <= BAUD_MAX;
            bit_cnt  <= 4'd9;
        end else if (active) begin
            if (baud_cnt == '0) begin
                if (bit_cnt == 4'd0) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    tx       <= shift[0];
                    shift    <= {1'b1, shift[8:1]};
                    bit_cnt  <= bit_cnt - 4'd1;
                    baud_cnt <= BAUD_MAX;
                end
            end else begin
                baud_cnt <= baud_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_bus_frame_tx.sv
// Bus-request framer: captures one read/write request and feeds the checksummed
// frame byte by byte into the 8N1 serialiser.
//
//  state   | meaning
//  IDLE    | ready for a request; SOF is offered to the serialiser on req_valid
//  SOF     | SOF on the line, CMD queued
//  CMD     | CMD on the line, first address byte queued
//  ADDR    | address byte on the line, next address/data/CHK byte queued
//  DATA    | data byte on the line, next data/CHK byte queued
//  CHK     | CHK on the line, waiting for its stop bit to finish
module uart_bus_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int SRC_ID       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              uart_tx,
    output logic              busy,
    output logic [15:0]       frames_sent
);

    localparam int AB  = bytes_for(ADDR_W);
    localparam int DB  = bytes_for(DATA_W);
    localparam int AW8 = AB * 8;
    localparam int DW8 = DB * 8;
    localparam logic [3:0] SRC_NIB = 4'(SRC_ID);

    frame_state_e   state;
    logic [AW8-1:0] addr_sh;
    logic [DW8-1:0] data_sh;
    logic           we_q;
    logic [7:0]     cmd_q;
    logic [7:0]     chk_q;
    logic [2:0]     idx;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       byte_done;
    logic       take;

    assign take = byte_valid && byte_ready;

    // The byte offered is always the one that follows the byte on the line,
    // so the serialiser can take it in its last stop-bit cycle.
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = SOF_BYTE;
        case (state)
            FS_IDLE: begin
                byte_valid = req_valid;
                byte_data  = SOF_BYTE;
            end
            FS_SOF: begin
                byte_valid = 1'b1;
                byte_data  = cmd_q;
            end
            FS_CMD: begin
                byte_valid = 1'b1;
                byte_data  = addr_sh[AW8-1 -: 8];
            end
            FS_ADDR: begin
                byte_valid = 1'b1;
                if (idx != 3'd0)
                    byte_data = addr_sh[AW8-1 -: 8];
                else if (we_q)
                    byte_data = data_sh[DW8-1 -: 8];
                else
                    byte_data = chk_q;
            end
            FS_DATA: begin
                byte_valid = 1'b1;
                if (idx != 3'd0)
                    byte_data = data_sh[DW8-1 -: 8];
                else
                    byte_data = chk_q;
            end
            default: begin
                byte_valid = 1'b0;
                byte_data  = SOF_BYTE;
            end
        endcase
    end

    // idx is the number of address/data bytes still to be queued in the field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FS_IDLE;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            frames_sent <= 16'd0;
            addr_sh     <= '0;
            data_sh     <= '0;
            we_q        <= 1'b0;
            cmd_q       <= 8'd0;
            chk_q       <= 8'd0;
            idx         <= 3'd0;
        end else begin
            case (state)
                FS_IDLE: begin
                    if (take) begin
                        state     <= FS_SOF;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        we_q      <= req_we;
                        addr_sh   <= AW8'(req_addr);
                        data_sh   <= DW8'(req_wdata);
                        cmd_q     <= make_cmd(req_we, SRC_NIB);
                        chk_q     <= make_cmd(req_we, SRC_NIB);
                    end
                end
                FS_SOF: begin
                    if (take)
                        state <= FS_CMD;
                end
                FS_CMD: begin
                    if (take) begin
                        state   <= FS_ADDR;
                        addr_sh <= addr_sh << 8;
                        idx     <= 3'(AB - 1);
                        chk_q   <= chk_q ^ byte_data;
                    end
                end
                FS_ADDR: begin
                    if (take) begin
                        if (idx != 3'd0) begin
                            addr_sh <= addr_sh << 8;
                            idx     <= idx - 3'd1;
                            chk_q   <= chk_q ^ byte_data;
                        end else if (we_q) begin
                            state   <= FS_DATA;
                            data_sh <= data_sh << 8;
                            idx     <= 3'(DB - 1);
                            chk_q   <= chk_q ^ byte_data;
                        end else begin
                            state <= FS_CHK;
                        end
                    end
                end
                FS_DATA: begin
                    if (take) begin
                        if (idx != 3'd0) begin
                            data_sh <= data_sh << 8;
                            idx     <= idx - 3'd1;
                            chk_q   <= chk_q ^ byte_data;
                        end else begin
                            state <= FS_CHK;
                        end
                    end
                end
                FS_CHK: begin
                    if (byte_done) begin
                        state       <= FS_IDLE;
                        req_ready   <= 1'b1;
                        busy        <= 1'b0;
                        frames_sent <= frames_sent + 16'd1;
                    end
                end
                default: begin
                    state     <= FS_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .byte_done  (byte_done),
        .tx         (uart_tx)
    );

endmodule

// File: tb/tb_uart_bus_frame_tx.sv
// Bench for uart_bus_frame_tx: two configurations checked cycle by cycle
// against a byte-list frame model expanded into an expected line waveform.
module tb_uart_bus_frame_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        tx_a, tx_b, ready_a, ready_b, busy_a, busy_b;
    logic [15:0] fs_a, fs_b;

    always #5 clk = ~clk;

    uart_bus_frame_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(16), .DATA_W(8), .SRC_ID(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a),
        .req_we(req_we), .req_addr(req_addr[15:0]), .req_wdata(req_wdata[7:0]),
        .uart_tx(tx_a), .busy(busy_a), .frames_sent(fs_a));

    uart_bus_frame_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(12), .DATA_W(32), .SRC_ID(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(ready_b),
        .req_we(req_we), .req_addr(req_addr[11:0]), .req_wdata(req_wdata),
        .uart_tx(tx_b), .busy(busy_b), .frames_sent(fs_b));

    bit          sel_r = 1'b0;
    logic        tx_s, ready_s, busy_s;
    logic [15:0] fs_s;
    assign tx_s    = sel_r ? tx_b    : tx_a;
    assign ready_s = sel_r ? ready_b : ready_a;
    assign busy_s  = sel_r ? busy_b  : busy_a;
    assign fs_s    = sel_r ? fs_b    : fs_a;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_bytes[$];
    logic [7:0] got_bytes[$];
    bit   wave[0:1023];
    int   exp_fs[2];
    int   hs_cyc, end_cyc, prev_end_cyc;
    bit   nx_we;
    logic [31:0] nx_addr, nx_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_valid(input bit v);
        if (sel_r) valid_b = v;
        else       valid_a = v;
    endtask

    // Frame model: byte list from the frame rules, widths from the instance.
    task automatic build_expected(input bit sel, input bit we, input logic [31:0] addr,
                                  input logic [31:0] data);
        int aw, dw, ab, db;
        logic [63:0] a, d;
        logic [7:0] cmd, chk, b;
        aw = sel ? 12 : 16;
        dw = sel ? 32 : 8;
        ab = (aw + 7) / 8;
        db = (dw + 7) / 8;
        a = {32'd0, addr} & ((64'd1 << aw) - 64'd1);
        d = {32'd0, data} & ((64'd1 << dw) - 64'd1);
        cmd = (we ? 8'h80 : 8'h00) | (sel ? 8'h01 : 8'h00);
        exp_bytes.delete();
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(cmd);
        chk = cmd;
        for (int k = ab - 1; k >= 0; k--) begin
            b = 8'((a >> (8 * k)) & 64'hFF);
            exp_bytes.push_back(b);
            chk ^= b;
        end
        if (we) begin
            for (int k = db - 1; k >= 0; k--) begin
                b = 8'((d >> (8 * k)) & 64'hFF);
                exp_bytes.push_back(b);
                chk ^= b;
            end
        end
        exp_bytes.push_back(chk);
    endtask

    function automatic bit exp_bit(input int i);
        int b, p;
        b = i / (10 * CPB);
        p = (i % (10 * CPB)) / CPB;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return exp_bytes[b][p-1];
    endfunction

    // Called and returns just after a negedge. mode 0: drop valid after the
    // handshake; 1: hold valid with nx_* request; 2: toggle valid while busy.
    task automatic do_frame(input bit sel, input bit we, input logic [31:0] addr,
                            input logic [31:0] data, input int mode, input bit chained);
        int n, L, werr, berr;
        logic [7:0] g;
        sel_r = sel;
        build_expected(sel, we, addr, data);
        L = exp_bytes.size() * 10 * CPB;
        req_we = we; req_addr = addr; req_wdata = data;
        set_valid(1'b1);
        n = 0;
        while (!ready_s && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("handshake_wait", (n < 5000), 1);
        if (n >= 5000) begin
            set_valid(1'b0);
            return;
        end
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        if (chained) check("b2b_start", hs_cyc, prev_end_cyc + 1);
        if (mode == 1) begin
            req_we = nx_we; req_addr = nx_addr; req_wdata = nx_data;
        end else begin
            set_valid(1'b0);
            req_addr = $urandom; req_wdata = $urandom; req_we = ~we;
        end
        werr = 0; berr = 0;
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            wave[i] = tx_s;
            if (tx_s !== exp_bit(i)) werr++;
            if (ready_s !== 1'b0 || busy_s !== 1'b1) berr++;
            if (mode == 2) begin
                if (i == L - 1) set_valid(1'b0);
                else if (i % 9 == 4) begin
                    set_valid((i / 9) % 2 == 0);
                    req_addr = $urandom;
                    req_we = 1'($urandom);
                end
            end
        end
        check("wave_errors", werr, 0);
        check("busy_during_frame", berr, 0);
        got_bytes.delete();
        for (int b = 0; b < exp_bytes.size(); b++) begin
            for (int j = 0; j < 8; j++) g[j] = wave[b*10*CPB + (j+1)*CPB + CPB/2];
            got_bytes.push_back(g);
            check($sformatf("byte%0d", b), g, exp_bytes[b]);
        end
        @(negedge clk);
        end_cyc = cyc;
        prev_end_cyc = end_cyc;
        exp_fs[sel] = (exp_fs[sel] + 1) & 16'hFFFF;
        check("frame_cycles", end_cyc - hs_cyc, L);
        check("ready_after", ready_s, 1);
        check("busy_after", busy_s, 0);
        check("tx_gap_high", tx_s, 1);
        check("frames_sent", fs_s, exp_fs[sel]);
    endtask

    typedef struct {
        bit          sel;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        int          exp_n;
        logic [7:0]  exp_chk;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n, idle_err;
        vecs[0] = '{sel: 1'b0, we: 1'b1, addr: 32'h1234, data: 32'hFF,       exp_n: 6, exp_chk: 8'h59};
        vecs[1] = '{sel: 1'b1, we: 1'b0, addr: 32'h0010, data: 32'h0,        exp_n: 5, exp_chk: 8'h11};
        vecs[2] = '{sel: 1'b1, we: 1'b1, addr: 32'hABC,  data: 32'hDEADBEEF, exp_n: 9, exp_chk: 8'h15};
        vecs[3] = '{sel: 1'b0, we: 1'b0, addr: 32'hBEEF, data: 32'h77,       exp_n: 5, exp_chk: 8'h51};
        vecs[4] = '{sel: 1'b0, we: 1'b1, addr: 32'h0000, data: 32'h00,      exp_n: 6, exp_chk: 8'h80};
        exp_fs[0] = 0; exp_fs[1] = 0;

        repeat (3) @(negedge clk);
        check("rst_tx_a", tx_a, 1);
        check("rst_ready_a", ready_a, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_fs_a", fs_a, 0);
        check("rst_tx_b", tx_b, 1);
        check("rst_fs_b", fs_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            do_frame(vecs[v].sel, vecs[v].we, vecs[v].addr, vecs[v].data, 0, 1'b0);
            check($sformatf("vec%0d_len", v), end_cyc - hs_cyc, vecs[v].exp_n * 10 * CPB);
            check($sformatf("vec%0d_chk", v), got_bytes[got_bytes.size()-1], vecs[v].exp_chk);
        end

        // Back-to-back: valid held, inputs changed to the second request mid-frame.
        nx_we = 1'b0; nx_addr = 32'h4321; nx_data = 32'h99;
        do_frame(1'b0, 1'b1, 32'hCAFE, 32'h5A, 1, 1'b0);
        do_frame(1'b0, 1'b0, 32'h4321, 32'h99, 0, 1'b1);

        // Requests pulsed while busy must not be queued.
        do_frame(1'b1, 1'b1, 32'h123, 32'h01020304, 2, 1'b0);
        idle_err = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_b !== 1'b1 || ready_b !== 1'b1 || fs_b !== 16'(exp_fs[1])) idle_err++;
        end
        check("no_queued_frame", idle_err, 0);

        // Reset in the middle of the first address byte.
        sel_r = 1'b0;
        req_we = 1'b1; req_addr = 32'h5A5A; req_wdata = 32'h3C;
        valid_a = 1'b1;
        n = 0;
        while (!ready_a && n < 5000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        repeat (2 * 10 * CPB + 5) @(negedge clk);
        check("pre_reset_tx_low", tx_a, 0);
        check("pre_reset_busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_tx", tx_a, 1);
        check("mid_reset_ready", ready_a, 1);
        check("mid_reset_busy", busy_a, 0);
        check("mid_reset_fs_a", fs_a, 0);
        check("mid_reset_fs_b", fs_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_fs[0] = 0; exp_fs[1] = 0;
        idle_err = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || ready_a !== 1'b1) idle_err++;
        end
        check("no_resume_after_reset", idle_err, 0);
        do_frame(1'b0, 1'b1, 32'h5A5A, 32'h3C, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            do_frame(1'($urandom), 1'($urandom), $urandom, $urandom, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
